// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: next-PC select encoding
// and the default reset/exception vectors.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_HOLD,
        SEL_BR,
        SEL_RET,
        SEL_JMP,
        SEL_SEQ
    } NextPcSel_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: overwrites the oldest entry when full and
// replaces the top entry when a push and a pop arrive together.
module pc_return_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] entries_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] topIdx;
    logic [PTR_W-1:0] writeIdx;
    logic             writeEn;

    // ptr_q is the next free slot, so the top lives one below it
    assign topIdx = ptr_q - PTR_W'(1);
    assign top    = entries_q[topIdx];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        ptr_d    = ptr_q;
        count_d  = count_q;
        writeEn  = 1'b0;
        writeIdx = ptr_q;
        if (push && pop && !empty) begin
            writeEn  = 1'b1;
            writeIdx = topIdx;
        end else if (push) begin
            writeEn  = 1'b1;
            writeIdx = ptr_q;
            ptr_d    = ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = topIdx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (writeEn) begin
            entries_q[writeIdx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC select, exception PC
// capture and call/return prediction through a small return stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          INC          = 4,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Exception,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic             Call,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Return,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlus,
    output logic [WIDTH-1:0] EPC,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasUnderflow
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    NextPcSel_e       nextSel;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rasTop;
    logic             callReq;
    logic             rasPush;
    logic             rasPop;

    assign PCPlus       = pc_q + WIDTH'(INC);
    assign PCResult     = pc_q;
    assign EPC          = epc_q;
    assign RasUnderflow = underflow_q;
    assign callReq      = Jump && Call;

    always_comb begin
        if (Reset)            nextSel = SEL_RESET;
        else if (Exception)   nextSel = SEL_EXC;
        else if (Stall)       nextSel = SEL_HOLD;
        else if (BranchTaken) nextSel = SEL_BR;
        else if (Return)      nextSel = SEL_RET;
        else if (Jump)        nextSel = SEL_JMP;
        else                  nextSel = SEL_SEQ;
    end

    // A Return that coincides with a call still pushes, which the stack
    // turns into a top-entry replacement
    assign rasPush = ((nextSel == SEL_RET) || (nextSel == SEL_JMP)) && callReq;
    assign rasPop  = (nextSel == SEL_RET);

    always_comb begin
        pc_d        = PCPlus;
        epc_d       = epc_q;
        underflow_d = 1'b0;
        case (nextSel)
            SEL_RESET: begin
                pc_d  = RST_PC;
                epc_d = '0;
            end
            SEL_EXC: begin
                pc_d  = EXC_PC;
                epc_d = pc_q;
            end
            SEL_HOLD: pc_d = pc_q;
            SEL_BR:   pc_d = BranchTarget;
            SEL_RET: begin
                pc_d        = RasEmpty ? PCPlus : rasTop;
                underflow_d = RasEmpty && !callReq;
            end
            SEL_JMP:  pc_d = JumpTarget;
            default:  pc_d = PCPlus;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q        <= RST_PC;
            epc_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            underflow_q <= underflow_d;
        end
    end

    pc_return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (rasPush),
        .pop       (rasPop),
        .push_data (PCPlus),
        .top       (rasTop),
        .empty     (RasEmpty),
        .full      (RasFull)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main scenarios and
// an 8-bit instance for address wrap-around.
module tb_pc_unit;

    logic        Clk;
    logic        Reset, Stall, Exception, BranchTaken, Jump, Call, Return;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] PCResult, PCPlus, EPC;
    logic        RasEmpty, RasFull, RasUnderflow;

    logic        reset8, jump8;
    logic [7:0]  jumpTarget8;
    logic [7:0]  pcResult8, pcPlus8, epc8;
    logic        rasEmpty8, rasFull8, rasUnderflow8;

    int compareCount  = 0;
    int mismatchCount = 0;

    pc_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Exception    (Exception),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .Call         (Call),
        .JumpTarget   (JumpTarget),
        .Return       (Return),
        .PCResult     (PCResult),
        .PCPlus       (PCPlus),
        .EPC          (EPC),
        .RasEmpty     (RasEmpty),
        .RasFull      (RasFull),
        .RasUnderflow (RasUnderflow)
    );

    pc_unit #(.WIDTH(8)) dut8 (
        .Clk          (Clk),
        .Reset        (reset8),
        .Stall        (1'b0),
        .Exception    (1'b0),
        .BranchTaken  (1'b0),
        .BranchTarget (8'h00),
        .Jump         (jump8),
        .Call         (1'b0),
        .JumpTarget   (jumpTarget8),
        .Return       (1'b0),
        .PCResult     (pcResult8),
        .PCPlus       (pcPlus8),
        .EPC          (epc8),
        .RasEmpty     (rasEmpty8),
        .RasFull      (rasFull8),
        .RasUnderflow (rasUnderflow8)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the clock edge
    task automatic applyStimulus(input logic rst, input logic stall, input logic exc,
                                 input logic br, input logic [31:0] brTarget,
                                 input logic jmp, input logic call,
                                 input logic [31:0] jmpTarget, input logic ret);
        Reset        = rst;
        Stall        = stall;
        Exception    = exc;
        BranchTaken  = br;
        BranchTarget = brTarget;
        Jump         = jmp;
        Call         = call;
        JumpTarget   = jmpTarget;
        Return       = ret;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jumpCall(input logic [31:0] target);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, target, 0);
    endtask

    task automatic doReturn();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Exception = 1'b0; BranchTaken = 1'b0;
        Jump = 1'b0; Call = 1'b0; Return = 1'b0;
        BranchTarget = '0; JumpTarget = '0;
        reset8 = 1'b1; jump8 = 1'b0; jumpTarget8 = '0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset1_pc", PCResult, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset2_pc", PCResult, 32'h0);
        checkOutput("reset_epc", EPC, 32'h0);
        checkOutput("reset_empty", RasEmpty, 1);
        checkOutput("reset_full", RasFull, 0);
        checkOutput("reset_underflow", RasUnderflow, 0);

        idle(); checkOutput("seq_pc4", PCResult, 32'h4);
        idle(); checkOutput("seq_pc8", PCResult, 32'h8);
        idle(); checkOutput("seq_pc12", PCResult, 32'hC);
        checkOutput("seq_pcplus", PCPlus, 32'h10);
        idle(); checkOutput("seq_pc16", PCResult, 32'h10);

        applyStimulus(0, 1, 0, 0, 0, 1, 1, 32'h500, 0);
        checkOutput("stall1_pc", PCResult, 32'h10);
        checkOutput("stall_drops_call", RasEmpty, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall2_pc", PCResult, 32'h10);
        applyStimulus(0, 0, 0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("branch_pc", PCResult, 32'h40);
        idle(); checkOutput("after_branch_pc", PCResult, 32'h44);

        applyStimulus(0, 0, 0, 1, 32'h20, 1, 1, 32'h900, 1);
        checkOutput("branch_over_call_pc", PCResult, 32'h20);
        checkOutput("branch_over_call_empty", RasEmpty, 1);

        jumpCall(32'h100);
        checkOutput("call1_pc", PCResult, 32'h100);
        checkOutput("call1_empty", RasEmpty, 0);
        idle(); checkOutput("call1_seq", PCResult, 32'h104);
        jumpCall(32'h200);
        checkOutput("call2_pc", PCResult, 32'h200);
        idle(); checkOutput("call2_seq", PCResult, 32'h204);
        doReturn(); checkOutput("ret1_pc", PCResult, 32'h108);
        doReturn(); checkOutput("ret2_pc", PCResult, 32'h24);
        checkOutput("ret2_empty", RasEmpty, 1);
        checkOutput("ret2_underflow", RasUnderflow, 0);

        jumpCall(32'h300);
        jumpCall(32'h400);
        jumpCall(32'h500);
        checkOutput("fill3_full", RasFull, 0);
        jumpCall(32'h600);
        checkOutput("fill4_full", RasFull, 1);
        jumpCall(32'h700);
        checkOutput("fill5_pc", PCResult, 32'h700);
        checkOutput("fill5_full", RasFull, 1);
        doReturn(); checkOutput("pop1_pc", PCResult, 32'h604);
        doReturn(); checkOutput("pop2_pc", PCResult, 32'h504);
        doReturn(); checkOutput("pop3_pc", PCResult, 32'h404);
        doReturn(); checkOutput("pop4_pc", PCResult, 32'h304);
        checkOutput("pop4_empty", RasEmpty, 1);
        checkOutput("pop4_underflow", RasUnderflow, 0);
        doReturn(); checkOutput("pop5_pc", PCResult, 32'h308);
        checkOutput("pop5_underflow", RasUnderflow, 1);
        idle(); checkOutput("post_underflow_pc", PCResult, 32'h30C);
        checkOutput("underflow_pulse_end", RasUnderflow, 0);

        jumpCall(32'h30);
        checkOutput("pre_exc_pc", PCResult, 32'h30);
        applyStimulus(0, 1, 1, 1, 32'h999, 0, 0, 0, 1);
        checkOutput("exc_pc", PCResult, 32'h80);
        checkOutput("exc_epc", EPC, 32'h30);
        checkOutput("exc_ras_kept", RasEmpty, 0);
        doReturn(); checkOutput("exc_ret_pc", PCResult, 32'h310);
        checkOutput("exc_ret_empty", RasEmpty, 1);
        checkOutput("epc_held", EPC, 32'h30);

        jumpCall(32'h500);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h900, 1);
        checkOutput("retcall_pc", PCResult, 32'h314);
        checkOutput("retcall_empty", RasEmpty, 0);
        doReturn(); checkOutput("retcall_pop_pc", PCResult, 32'h504);
        checkOutput("retcall_pop_empty", RasEmpty, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h900, 1);
        checkOutput("retcall_empty_pc", PCResult, 32'h508);
        checkOutput("retcall_empty_underflow", RasUnderflow, 0);
        checkOutput("retcall_empty_count1", RasEmpty, 0);
        doReturn(); checkOutput("retcall_empty_pop_pc", PCResult, 32'h508);
        checkOutput("retcall_empty_pop_empty", RasEmpty, 1);
        doReturn(); checkOutput("underflow2_pc", PCResult, 32'h50C);
        checkOutput("underflow2_flag", RasUnderflow, 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h900, 0);
        checkOutput("call_only_pc", PCResult, 32'h510);
        checkOutput("call_only_empty", RasEmpty, 1);
        checkOutput("call_only_underflow", RasUnderflow, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("stall_ret_pc", PCResult, 32'h510);
        checkOutput("stall_ret_underflow", RasUnderflow, 0);

        jumpCall(32'h700);
        checkOutput("pre_reset_empty", RasEmpty, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset_ret_pc", PCResult, 32'h0);
        checkOutput("reset_ret_empty", RasEmpty, 1);
        checkOutput("reset_ret_epc", EPC, 32'h0);
        checkOutput("reset_ret_underflow", RasUnderflow, 0);
        idle(); checkOutput("after_reset_pc", PCResult, 32'h4);

        reset8 = 1'b0; jump8 = 1'b1; jumpTarget8 = 8'hFC;
        @(posedge Clk); #1;
        checkOutput("w8_jump_pc", pcResult8, 32'hFC);
        checkOutput("w8_pcplus_wrap", pcPlus8, 32'h00);
        jump8 = 1'b0;
        @(posedge Clk); #1;
        checkOutput("w8_wrap_pc", pcResult8, 32'h00);
        @(posedge Clk); #1;
        checkOutput("w8_after_wrap_pc", pcResult8, 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
